// File: rtl/fifo_drain_pkg.sv
// fifo_drain_pkg: shared state type and default parameters for fifo_drain
package fifo_drain_pkg;
  localparam int DEF_DWIDTH = 16;
  localparam int DEF_DEPTH = 8;
  localparam int DEF_BURST_LEN = 4;
  localparam int DEF_TIMEOUT = 16;
  typedef enum logic [1:0] {IDLE, XFER, LAST} state_e;
endpackage

// File: rtl/fifo_drain_timer.sv
// drain_timer: saturating idle counter; expired while the count sits at TIMEOUT
module drain_timer #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic expired
);
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] cnt_q, cnt_d;
  always_comb cnt_d = clr ? '0 : (inc && cnt_q != TW'(TIMEOUT)) ? cnt_q + 1'b1 : cnt_q;
  assign expired = cnt_q == TW'(TIMEOUT);
  always_ff @(posedge clk) cnt_q <= rst ? '0 : cnt_d;
endmodule

// File: rtl/fifo_drain.sv
// fifo_drain: pops bursts from a show-ahead FIFO into a registered valid/ready stream
module fifo_drain import fifo_drain_pkg::*; #(
  parameter int DWIDTH = DEF_DWIDTH,
  parameter int DEPTH = DEF_DEPTH,
  parameter int BURST_LEN = DEF_BURST_LEN,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       fifo_empty,
  input  logic [$clog2(DEPTH):0]     fifo_numel,
  input  logic [DWIDTH-1:0]          fifo_data,
  output logic                       fifo_rd_en,
  input  logic                       flush,
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic [DWIDTH-1:0]          m_data,
  output logic                       m_last,
  output logic                       busy
);
  localparam int NW = $clog2(DEPTH) + 1;
  state_e state_q, state_d;
  logic [NW-1:0] rem_q, rem_d;
  logic [DWIDTH-1:0] m_data_q, m_data_d;
  logic m_valid_q, m_valid_d, m_last_q, m_last_d;
  logic expired, pop, hs;
  drain_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk(clk),
    .rst(rst),
    .inc(state_q == IDLE && !fifo_empty),
    .clr(state_q != IDLE || fifo_empty),
    .expired(expired)
  );
  always_comb begin
    pop = state_q == XFER && rem_q != '0 && !fifo_empty && (!m_valid_q || m_ready);
    hs = m_valid_q && m_ready;
    m_valid_d = pop || (m_valid_q && !m_ready);
    m_data_d = pop ? fifo_data : m_data_q;
    m_last_d = pop ? rem_q == NW'(1) : m_last_q && !hs;
    rem_d = pop ? rem_q - 1'b1 : rem_q;
    state_d = state_q;
    if (state_q == IDLE && !fifo_empty && (flush || expired)) begin
      state_d = XFER;
      rem_d = fifo_numel;
    end else if (state_q == IDLE && fifo_numel >= NW'(BURST_LEN)) begin
      state_d = XFER;
      rem_d = NW'(BURST_LEN);
    end else if (pop && rem_q == NW'(1)) begin
      state_d = LAST;
    end else if (state_q == LAST && hs) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      rem_q <= '0;
      m_valid_q <= 1'b0;
      m_last_q <= 1'b0;
      m_data_q <= '0;
    end else begin
      state_q <= state_d;
      rem_q <= rem_d;
      m_valid_q <= m_valid_d;
      m_last_q <= m_last_d;
      m_data_q <= m_data_d;
    end
  end
  assign fifo_rd_en = pop;
  assign busy = state_q != IDLE;
  assign m_valid = m_valid_q;
  assign m_data = m_data_q;
  assign m_last = m_last_q;
endmodule

// File: doc/fifo_drain.md
FIFO_DRAIN -- requirements
Module: fifo_drain

Interface
REQ-001 Parameter DWIDTH, 16, data word width; equals sync_fifo FIFO_DWIDTH.
REQ-002 Parameter DEPTH, 8, sync_fifo depth; fifo_numel width is $clog2(DEPTH)+1.
REQ-003 Parameter BURST_LEN, 4, words per threshold burst; legal range 1..DEPTH.
REQ-004 Parameter TIMEOUT, 16, idle cycles before a partial burst is flushed; minimum 1.
REQ-005 Clocking: one clock; reset is synchronous and active-high.
REQ-006 clk  input  1  sole clock, rising edge.
REQ-007 rst  input  1  synchronous active-high reset.
REQ-008 fifo_empty  input  1  sync_fifo empty flag.
REQ-009 fifo_numel  input  $clog2(DEPTH)+1  sync_fifo occupancy.
REQ-010 fifo_data  input  DWIDTH  sync_fifo head word; show-ahead, valid whenever fifo_empty=0.
REQ-011 fifo_rd_en  output  1  pop strobe to sync_fifo; one word removed per high cycle.
REQ-012 flush  input  1  single-cycle request to drain all current contents.
REQ-013 m_valid  output  1  output word valid.
REQ-014 m_ready  input  1  downstream accept.
REQ-015 m_data  output  DWIDTH  output word.
REQ-016 m_last  output  1  marks final word of a burst; qualified by m_valid.
REQ-017 busy  output  1  high whenever state is not IDLE.

Function
REQ-018 States IDLE, XFER, LAST; state register encoded per the package enum.
REQ-019 IDLE->XFER when fifo_numel>=BURST_LEN; burst count latched = BURST_LEN.
REQ-020 IDLE->XFER when idle timer reaches TIMEOUT with fifo_empty=0; burst count latched = fifo_numel.
REQ-021 IDLE->XFER on flush with fifo_empty=0; burst count latched = fifo_numel.
REQ-022 If flush and the threshold condition coincide, flush wins (count = fifo_numel).
REQ-023 Flush with fifo_empty=1 is dropped; flush while busy is ignored, not queued.
REQ-024 Idle timer increments each IDLE cycle with fifo_empty=0, saturates at TIMEOUT, and clears on fifo_empty=1 or on leaving IDLE.
REQ-025 Output register: m_valid/m_data/m_last are registered; m_data holds stable while m_valid=1 and m_ready=0.
REQ-026 fifo_rd_en = (state==XFER) & remaining>0 & !fifo_empty & (!m_valid | m_ready); combinational.
REQ-027 On a pop the next edge loads m_data=fifo_data, sets m_valid=1, and decrements remaining; latency FIFO head -> m_valid is 1 cycle.
REQ-028 m_valid clears on handshake (m_valid & m_ready) unless a pop occurs in the same cycle.
REQ-029 Throughput is 1 word/cycle while m_ready=1 and FIFO non-empty; no bubbles within a burst.
REQ-030 m_last=1 on the word loaded when remaining goes 1->0; XFER->LAST on that edge.
REQ-031 LAST->IDLE on the handshake of the m_last word; m_valid=0 the following cycle.
REQ-032 fifo_empty=1 mid-burst stalls pops without error; burst resumes when words arrive.
REQ-033 Concurrent upstream writes do not change the latched burst count.
REQ-034 remaining counter width $clog2(DEPTH)+1; never underflows.

Reset
REQ-035 rst=1 forces state=IDLE, remaining=0, timer=0, m_valid=0, m_last=0, m_data=0, fifo_rd_en=0, busy=0 at next edge.
REQ-036 rst mid-burst abandons the burst; words already popped are lost; the FIFO is not reset by this block.

Structure
REQ-037 Package fifo_drain_pkg holds the state enum type and default parameter constants (DWIDTH, DEPTH, BURST_LEN, TIMEOUT).
REQ-038 One sub-module, drain_timer: saturating idle counter with clear and an expired output; all other logic is in fifo_drain.

Verification
REQ-039 Bench instantiates sync_fifo + fifo_drain (DEPTH=8, BURST_LEN=4, TIMEOUT=16) and checks words against a scoreboard in write order.
REQ-040 Write 4 words, m_ready=1 -> burst starts within 1 cycle of numel=4; 4 consecutive m_valid cycles, m_last on 4th; FIFO empty after.
REQ-041 Write 2 words, then idle -> no output for 16 cycles; then a 2-word burst with m_last on 2nd.
REQ-042 Write 8 words, m_ready toggling 1/0 -> two 4-word bursts; m_data stable during stalls; 8 words in order.
REQ-043 Write 3 words, pulse flush, then write 1 more mid-burst -> 3-word burst with m_last on word 3; 4th word waits for timeout.
REQ-044 Assert rst during word 2 of a 4-word burst -> all outputs 0 next cycle, state IDLE; remaining FIFO contents drain correctly afterward.
